// File: rtl/pdp8_panel_loader.sv
// pdp8_panel_loader
// Drives the PDP-8 Front_Panel switch register and Load-PC/Deposit buttons
// to load a memory image word by word. It then loads the start PC, raises
// the run switch and reports a halt when the CPU run LED falls.
//
// Handshake: an image word transfers on a rising clock edge where
// in_valid && in_ready are both 1. in_ready is a register that is 1 only
// while the loader waits for a word. It does not depend combinationally on
// in_valid. Once the producer raises in_valid, it holds in_valid and the
// word fields stable until the transfer happens.
//
// Every button action is a three-phase sequence. SETUP puts the value on
// sw[11:0]. PULSE holds the button high. GAP releases the button and keeps
// sw steady. Each phase lasts exactly its parameter in cycles.

module pdp8_panel_loader #(
    parameter int unsigned SETUP_CYCLES  = 10,
    parameter int unsigned PULSE_CYCLES  = 10,
    parameter int unsigned GAP_CYCLES    = 30,
    parameter int unsigned AUTO_INC_SKIP = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] start_pc,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_addr,
    input  logic [11:0] in_data,
    input  logic        in_last,
    input  logic        run_led,
    output logic [12:0] sw,
    output logic        btnl,
    output logic        btnd,
    output logic        busy,
    output logic        halted,
    output logic [12:0] words_loaded,
    output logic [3:0]  dbg_state
);

    // Sequencer states
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WAIT_WORD = 4'd1;
    localparam logic [3:0] ST_A_SETUP   = 4'd2;
    localparam logic [3:0] ST_A_PULSE   = 4'd3;
    localparam logic [3:0] ST_A_GAP     = 4'd4;
    localparam logic [3:0] ST_D_SETUP   = 4'd5;
    localparam logic [3:0] ST_D_PULSE   = 4'd6;
    localparam logic [3:0] ST_D_GAP     = 4'd7;
    localparam logic [3:0] ST_S_SETUP   = 4'd8;
    localparam logic [3:0] ST_S_PULSE   = 4'd9;
    localparam logic [3:0] ST_S_GAP     = 4'd10;
    localparam logic [3:0] ST_RUN       = 4'd11;
    localparam logic [3:0] ST_HALTED    = 4'd12;

    // Terminal counts for each phase; the phase counter runs 0..N-1
    localparam logic [15:0] LAST_SETUP = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] LAST_PULSE = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] LAST_GAP   = 16'(GAP_CYCLES - 1);

    localparam logic [12:0] WORDS_MAX  = 13'd4096;

    logic [3:0]  r_state;
    logic [15:0] r_cnt;
    logic [11:0] r_addr;
    logic [11:0] r_data;
    logic        r_last;
    logic [11:0] r_start_pc;
    logic [11:0] r_prev_addr;
    logic        r_prev_vld;
    logic        r_led_prev;
    logic        r_led_seen;
    logic [12:0] r_sw;
    logic        r_btnl;
    logic        r_btnd;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_halted;
    logic [12:0] r_words;

    logic [15:0] w_phase_last;
    logic        w_phase_done;
    logic        w_take;
    logic [11:0] w_prev_inc;
    logic        w_skip;
    logic        w_led_fall;

    // Select the terminal count of the phase the sequencer is currently in
    always_comb begin
        w_phase_last = LAST_SETUP;
        case (r_state)
            ST_A_PULSE, ST_D_PULSE, ST_S_PULSE: w_phase_last = LAST_PULSE;
            ST_A_GAP,   ST_D_GAP,   ST_S_GAP:   w_phase_last = LAST_GAP;
            default:                            w_phase_last = LAST_SETUP;
        endcase
    end

    assign w_phase_done = (r_cnt == w_phase_last);
    assign w_take       = in_valid & r_in_ready;
    // 12-bit add wraps 7777 -> 0000, matching the CPU's address increment
    assign w_prev_inc   = r_prev_addr + 12'd1;
    assign w_skip       = (AUTO_INC_SKIP != 0) && r_prev_vld && (in_addr == w_prev_inc);
    // Halt only on a real high-to-low edge after the CPU was seen running
    assign w_led_fall   = r_led_seen & r_led_prev & ~run_led;

    // Main sequencer: state, phase counter, captured word and panel outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_start_pc  <= '0;
            r_prev_addr <= '0;
            r_prev_vld  <= 1'b0;
            r_led_prev  <= 1'b0;
            r_led_seen  <= 1'b0;
            r_sw        <= '0;
            r_btnl      <= 1'b0;
            r_btnd      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_words     <= '0;
        end else begin
            r_led_prev <= run_led;
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_start_pc <= start_pc;
                        r_words    <= '0;
                        r_halted   <= 1'b0;
                        r_prev_vld <= 1'b0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_WAIT_WORD;
                    end
                end

                ST_WAIT_WORD: begin
                    if (w_take) begin
                        r_addr     <= in_addr;
                        r_data     <= in_data;
                        r_last     <= in_last;
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        if (w_skip) begin
                            r_sw[11:0] <= in_data;
                            r_state    <= ST_D_SETUP;
                        end else begin
                            r_sw[11:0] <= in_addr;
                            r_state    <= ST_A_SETUP;
                        end
                    end
                end

                ST_A_SETUP: begin
                    if (w_phase_done) begin
                        r_cnt   <= '0;
                        r_btnl  <= 1'b1;
                        r_state <= ST_A_PULSE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_A_PULSE: begin
                    if (w_phase_done) begin
                        r_cnt   <= '0;
                        r_btnl  <= 1'b0;
                        r_state <= ST_A_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_A_GAP: begin
                    if (w_phase_done) begin
                        r_cnt      <= '0;
                        r_sw[11:0] <= r_data;
                        r_state    <= ST_D_SETUP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_D_SETUP: begin
                    if (w_phase_done) begin
                        r_cnt   <= '0;
                        r_btnd  <= 1'b1;
                        r_state <= ST_D_PULSE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_D_PULSE: begin
                    if (w_phase_done) begin
                        r_cnt   <= '0;
                        r_btnd  <= 1'b0;
                        r_state <= ST_D_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_D_GAP: begin
                    if (w_phase_done) begin
                        r_cnt       <= '0;
                        r_prev_addr <= r_addr;
                        r_prev_vld  <= 1'b1;
                        if (r_words != WORDS_MAX) begin
                            r_words <= r_words + 13'd1;
                        end
                        if (r_last) begin
                            r_sw[11:0] <= r_start_pc;
                            r_state    <= ST_S_SETUP;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= ST_WAIT_WORD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_S_SETUP: begin
                    if (w_phase_done) begin
                        r_cnt   <= '0;
                        r_btnl  <= 1'b1;
                        r_state <= ST_S_PULSE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_S_PULSE: begin
                    if (w_phase_done) begin
                        r_cnt   <= '0;
                        r_btnl  <= 1'b0;
                        r_state <= ST_S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_S_GAP: begin
                    if (w_phase_done) begin
                        r_cnt      <= '0;
                        r_sw[12]   <= 1'b1;
                        r_led_seen <= 1'b0;
                        r_state    <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_RUN: begin
                    if (run_led) begin
                        r_led_seen <= 1'b1;
                    end
                    if (w_led_fall) begin
                        r_sw[12] <= 1'b0;
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_HALTED;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sw           = r_sw;
    assign btnl         = r_btnl;
    assign btnd         = r_btnd;
    assign in_ready     = r_in_ready;
    assign busy         = r_busy;
    assign halted       = r_halted;
    assign words_loaded = r_words;
    assign dbg_state    = r_state;

endmodule

// File: doc/pdp8_panel_loader.md
Name: pdp8_panel_loader

Overview:
Synthesizable sequencer that drives the PDP-8 Front_Panel switch and button inputs to load a memory image and start execution, replacing the bench's timed Load_PC/Deposit tasks. It accepts (address, data) words over a valid/ready stream and issues paced Load-PC and Deposit button pulses. After the last word it loads the start PC, raises the run switch, and reports halt when the CPU run LED falls.

Parameters:
SETUP_CYCLES, 10, cycles sw[11:0] is held stable before a button asserts (min 1)
PULSE_CYCLES, 10, cycles a button is held high (min 1)
GAP_CYCLES, 30, cycles after button release before the next action (min 1)
AUTO_INC_SKIP, 1, if 1, skip Load-PC when the address equals the previous address + 1 (mod 4096)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load session (ignored unless busy=0)
start_pc  in  12  PC loaded before run; sampled on start
in_valid  in  1  image word valid
in_ready  out  1  loader accepts a word this cycle
in_addr  in  12  word address
in_data  in  12  word data
in_last  in  1  marks the final image word
run_led  in  1  Front_Panel led[12]
sw  out  13  switch register to Front_Panel; [12] is the run switch
btnl  out  1  Load-PC button
btnd  out  1  Deposit button
busy  out  1  session active (start accepted, not yet halted)
halted  out  1  CPU stopped after run; sticky until next start/reset
words_loaded  out  13  count of deposits in this session (saturates at 4096)

Behaviour:
- Reset (synchronous, active-high, overrides all): state=IDLE; sw=0, btnl=0, btnd=0, in_ready=0, busy=0, halted=0, words_loaded=0, prev-address valid flag cleared. Reset mid-session drops buttons and sw[12] on the next edge.
- States: IDLE, WAIT_WORD, A_SETUP, A_PULSE, A_GAP, D_SETUP, D_PULSE, D_GAP, S_SETUP, S_PULSE, S_GAP, RUN, HALTED.
- IDLE: start=1 -> capture start_pc, clear words_loaded/halted/prev flag, busy=1, go WAIT_WORD.
- WAIT_WORD: in_ready=1 (registered, only in this state). Handshake on in_valid&in_ready: capture addr/data/last. If AUTO_INC_SKIP=1, prev flag set and addr==prev+1 (12-bit wrap, 7777->0000) -> D_SETUP; else -> A_SETUP.
- A_SETUP: sw[11:0]=addr for SETUP_CYCLES cycles; A_PULSE: btnl=1 for PULSE_CYCLES; A_GAP: btnl=0, sw held, GAP_CYCLES; -> D_SETUP.
- D_SETUP/D_PULSE/D_GAP: same timing with sw[11:0]=data, btnd=1 during pulse. At D_GAP exit: words_loaded+1 (saturating), prev=addr, prev flag=1; last=1 -> S_SETUP else WAIT_WORD.
- S_SETUP/S_PULSE/S_GAP: Load-PC sequence with sw[11:0]=start_pc; then sw[12]=1, go RUN.
- RUN: sw[12]=1. run_led 1->0 transition (registered previous value, seen high at least once in RUN) -> sw[12]=0, halted=1, busy=0, go HALTED. run_led never high: stay RUN.
- HALTED: outputs hold; start=1 behaves as in IDLE.
- Buttons are never both high; sw[11:0] never changes while a button is high or during the cycle it falls.
- Each phase lasts exactly its parameter in cycles; a button is high for exactly PULSE_CYCLES consecutive cycles.
- start while busy=1 is ignored; in_valid outside WAIT_WORD is not accepted.

Test Plan:
- Reset mid A_PULSE with addr=0200 -> next edge btnl=0, sw=0, state IDLE, in_ready=0.
- Single word addr=0200 data=7402 last=1, start_pc=0200 -> btnl pulse with sw=0200, btnd pulse with sw=7402, btnl pulse with sw=0200, sw[12]=1; each pulse exactly 10 cycles, 10 setup, 30 gap; words_loaded=1.
- Consecutive addrs 0200,0201,0202 with AUTO_INC_SKIP=1 -> one btnl pulse and three btnd pulses; with AUTO_INC_SKIP=0 -> three btnl pulses.
- Wrap: addrs 7777 then 0000 -> second word has no btnl pulse; addrs 0300 then 0200 -> btnl issued.
- in_valid held low 50 cycles in WAIT_WORD -> in_ready stays 1, no button activity; start pulsed during D_PULSE -> ignored.
- In RUN, run_led rises then falls -> next edge sw[12]=0, halted=1, busy=0; new start clears halted and words_loaded.
